rx_core_mc: RTL

Multi-channel, parametrised successor of the three-channel receive core control path. Holds per-channel DDC/DUC phase increments behind a shadow/active register pair with an atomic commit handshake, and blanks each retuned channel's DAC output for a settling window while the downstream NCO pipeline flushes. Provides per-channel output routing: normal, ADC bypass, zero, or hold. Sits between the register interface and the per-channel DSP chains. It drives their phase increments and registers their outputs onto the DAC buses.

---
 rtl/rx_core_pkg.sv | 25 ++
 rtl/rx_core_chan_slice.sv | 99 +++++++++
 rtl/rx_core_mc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rx_core_pkg.sv
// rx_core_pkg: shared types and constants for the
// multi-channel receive core control path.
package rx_core_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SETTLE,
    DONE
  } state_e;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_ADC    = 2'd1;
  localparam logic [1:0] MODE_ZERO   = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  typedef struct packed {
    logic                ddc;
    logic                duc;
    logic [SAMPLE_W-1:0] data;
  } chan_wr_t;

endpackage

// File: rtl/rx_core_chan_slice.sv
// rx_core_chan_slice: one channel's shadow/active increments,
// settle counter and registered DAC output mux.
module rx_core_chan_slice
  import rx_core_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int SETTLE_CYCLES  = 64
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  chan_wr_t                             wr,
  input  logic                                 apply,
  input  logic [1:0]                           mode,
  input  logic [SAMPLE_W*NUMBER_OF_LINE-1:0]   adc_data,
  input  logic [SAMPLE_W*NUMBER_OF_LINE-1:0]   chan_data,
  output logic [SAMPLE_W-1:0]                  ddc_inc,
  output logic [SAMPLE_W-1:0]                  duc_inc,
  output logic                                 dirty,
  output logic                                 settle_last,
  output logic [SAMPLE_W*NUMBER_OF_LINE-1:0]   dac_data
);

  localparam int DW = SAMPLE_W * NUMBER_OF_LINE;
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYCLES);

  logic [SAMPLE_W-1:0] ddc_sh_q, ddc_sh_d;
  logic [SAMPLE_W-1:0] duc_sh_q, duc_sh_d;
  logic [SAMPLE_W-1:0] ddc_act_q, ddc_act_d;
  logic [SAMPLE_W-1:0] duc_act_q, duc_act_d;
  logic                dirty_q, dirty_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DW-1:0]       dac_q, dac_d;
  logic                blank;

  assign blank       = (cnt_q != 16'd0);
  assign settle_last = (cnt_q <= 16'd1);
  assign ddc_inc     = ddc_act_q;
  assign duc_inc     = duc_act_q;
  assign dirty       = dirty_q;
  assign dac_data    = dac_q;

  always_comb begin
    ddc_sh_d  = ddc_sh_q;
    duc_sh_d  = duc_sh_q;
    ddc_act_d = ddc_act_q;
    duc_act_d = duc_act_q;
    dirty_d   = dirty_q;
    cnt_d     = cnt_q;
    if (blank) begin
      cnt_d = cnt_q - 16'd1;
    end
    if (apply && dirty_q) begin
      ddc_act_d = ddc_sh_q;
      duc_act_d = duc_sh_q;
      dirty_d   = 1'b0;
      cnt_d     = SETTLE_LD;
    end
    // writes only land while idle, never alongside apply
    if (wr.ddc) begin
      ddc_sh_d = wr.data;
      dirty_d  = 1'b1;
    end
    if (wr.duc) begin
      duc_sh_d = wr.data;
      dirty_d  = 1'b1;
    end
  end

  always_comb begin
    dac_d = dac_q;
    unique case (1'b1)
      (mode == MODE_NORMAL): dac_d = blank ? '0 : chan_data;
      (mode == MODE_ADC):    dac_d = adc_data;
      (mode == MODE_ZERO):   dac_d = '0;
      (mode == MODE_HOLD):   dac_d = dac_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ddc_sh_q  <= '0;
      duc_sh_q  <= '0;
      ddc_act_q <= '0;
      duc_act_q <= '0;
      dirty_q   <= 1'b0;
      cnt_q     <= '0;
      dac_q     <= '0;
    end else begin
      ddc_sh_q  <= ddc_sh_d;
      duc_sh_q  <= duc_sh_d;
      ddc_act_q <= ddc_act_d;
      duc_act_q <= duc_act_d;
      dirty_q   <= dirty_d;
      cnt_q     <= cnt_d;
      dac_q     <= dac_d;
    end
  end

endmodule

// File: rtl/rx_core_mc.sv
// rx_core_mc: config decode, commit FSM and per-channel
// slices for the multi-channel receive core.
module rx_core_mc
  import rx_core_pkg::*;
#(
  parameter int NUMBER_OF_LINE = 8,
  parameter int NUM_CHANNELS   = 3,
  parameter int SETTLE_CYCLES  = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [2:0]              cfg_chan,
  input  logic                    cfg_sel,
  input  logic [15:0]             cfg_data,
  output logic                    cfg_err,
  input  logic                    commit,
  output logic                    commit_done,
  input  logic [2*NUM_CHANNELS-1:0] output_select,
  output logic [16*NUM_CHANNELS-1:0] ddc_phase_inc,
  output logic [16*NUM_CHANNELS-1:0] duc_phase_inc,
  input  logic [16*NUMBER_OF_LINE-1:0] adc_data,
  input  logic [16*NUMBER_OF_LINE*NUM_CHANNELS-1:0] chan_data,
  output logic [16*NUMBER_OF_LINE*NUM_CHANNELS-1:0] dac_data
);

  localparam int DW = SAMPLE_W * NUMBER_OF_LINE;

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  logic   done_q, done_d;
  logic   err_q, err_d;

  logic [NUM_CHANNELS-1:0] dirty;
  logic [NUM_CHANNELS-1:0] settle_last;
  logic apply;
  logic chan_ok;
  logic accept;
  logic wr_ok;

  assign cfg_ready   = !reset && (state_q == IDLE);
  assign cfg_err     = err_q;
  assign commit_done = done_q;
  assign apply       = (state_q == APPLY);
  assign chan_ok     = {29'd0, cfg_chan} < 32'(NUM_CHANNELS);
  assign accept      = cfg_valid && cfg_ready;
  assign wr_ok       = accept && chan_ok;

  always_comb begin
    err_d = err_q;
    if (accept && !chan_ok) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (commit) state_d = APPLY;
      end
      (state_q == APPLY): begin
        if (commit) pending_d = 1'b1;
        if (|dirty) begin
          state_d = SETTLE;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      (state_q == SETTLE): begin
        if (commit) pending_d = 1'b1;
        // every counter reaches zero on this edge
        if (&settle_last) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      (state_q == DONE): begin
        if (pending_q || commit) begin
          state_d   = APPLY;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    chan_wr_t wr;
    logic     hit;

    assign hit     = wr_ok && (cfg_chan == 3'(i));
    assign wr.ddc  = hit && !cfg_sel;
    assign wr.duc  = hit && cfg_sel;
    assign wr.data = cfg_data;

    rx_core_chan_slice #(
      .NUMBER_OF_LINE(NUMBER_OF_LINE),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_slice (
      .clock      (clock),
      .reset      (reset),
      .wr         (wr),
      .apply      (apply),
      .mode       (output_select[2*i +: 2]),
      .adc_data   (adc_data),
      .chan_data  (chan_data[i*DW +: DW]),
      .ddc_inc    (ddc_phase_inc[i*SAMPLE_W +: SAMPLE_W]),
      .duc_inc    (duc_phase_inc[i*SAMPLE_W +: SAMPLE_W]),
      .dirty      (dirty[i]),
      .settle_last(settle_last[i]),
      .dac_data   (dac_data[i*DW +: DW])
    );
  end

endmodule
